// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button front end.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } btn_state_t;

   localparam int DEF_NUM_BTN         = 5;
   localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
   localparam int DEF_LONG_CYCLES     = 100_000_000;
   localparam int DEF_REPEAT_CYCLES   = 20_000_000;

   // Counter width able to hold n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce counter and press/long FSM.
// Auto-repeat logic is built only when BTN_AUTOREPEAT_EN is defined.
//
// state   | meaning
// IDLE    | debounced level low, waiting for an accepted rise
// PRESSED | level high, hold_cnt counting toward a long press
// HELD    | long press reported, waiting for release (repeat ticks if enabled)
module btn_channel
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic ev_press,
   output logic ev_release,
   output logic ev_long,
   output logic ev_repeat,
   output logic rise_next
);

   if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1) begin : g_bad_params
      $error("btn_channel: illegal timing parameters");
   end

   localparam int DW = cnt_w(DEBOUNCE_CYCLES);
   localparam int HW = cnt_w(LONG_CYCLES);
   localparam logic [DW-1:0] DEB_TC  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_TC = HW'(LONG_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          sync;
   logic [DW-1:0] deb_cnt;
   logic [HW-1:0] hold_cnt;
   btn_state_t    state;
   logic          accept;
   logic          rise;
   logic          fall;

   assign sync      = sync_q[1];
   assign accept    = (sync != level) && (deb_cnt == DEB_TC);
   assign rise      = accept && !level;
   assign fall      = accept && level;
   assign rise_next = rise;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         deb_cnt <= '0;
         level   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn};
         if (sync == level) begin
            deb_cnt <= '0;
         end else if (accept) begin
            level   <= ~level;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + DW'(1);
         end
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int RW = cnt_w(REPEAT_CYCLES);
   localparam logic [RW-1:0] REP_TC = RW'(REPEAT_CYCLES - 1);
   logic [RW-1:0] rep_cnt;
`else
   assign ev_repeat = 1'b0;
`endif

   // Event flags share the cycle in which level is updated, so press/release
   // line up with the first cycle of the new level.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         hold_cnt   <= '0;
         ev_press   <= 1'b0;
         ev_release <= 1'b0;
         ev_long    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         rep_cnt    <= '0;
         ev_repeat  <= 1'b0;
`endif
      end else begin
         ev_press   <= 1'b0;
         ev_release <= 1'b0;
         ev_long    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         ev_repeat  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (rise) begin
                  state    <= PRESSED;
                  ev_press <= 1'b1;
                  hold_cnt <= '0;
               end
            end
            PRESSED: begin
               if (fall) begin
                  state      <= IDLE;
                  ev_release <= 1'b1;
                  hold_cnt   <= '0;
               end else if (hold_cnt == HOLD_TC) begin
                  state    <= HELD;
                  ev_long  <= 1'b1;
                  hold_cnt <= '0;
`ifdef BTN_AUTOREPEAT_EN
                  rep_cnt  <= '0;
`endif
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            HELD: begin
               if (fall) begin
                  state      <= IDLE;
                  ev_release <= 1'b1;
               end
`ifdef BTN_AUTOREPEAT_EN
               // release wins over a coincident repeat tick
               if (fall || rep_cnt == REP_TC) rep_cnt <= '0;
               else                           rep_cnt <= rep_cnt + RW'(1);
               ev_repeat <= !fall && (rep_cnt == REP_TC);
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/btn_event_handler.sv
// Multi-channel button front end: NUM_BTN independent btn_channel instances
// plus a registered any_press. Auto-repeat enabled by defining BTN_AUTOREPEAT_EN.
module btn_event_handler
   import btn_pkg::*;
#(
   parameter int NUM_BTN         = DEF_NUM_BTN,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic [NUM_BTN-1:0] btn_long,
   output logic [NUM_BTN-1:0] btn_repeat,
   output logic               any_press
);

   if (NUM_BTN < 1) begin : g_bad_num
      $error("btn_event_handler: NUM_BTN must be at least 1");
   end

   logic [NUM_BTN-1:0] rise_next;

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
      btn_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .btn        (btn[gi]),
         .level      (btn_level[gi]),
         .ev_press   (btn_press[gi]),
         .ev_release (btn_release[gi]),
         .ev_long    (btn_long[gi]),
         .ev_repeat  (btn_repeat[gi]),
         .rise_next  (rise_next[gi])
      );
   end

   // Built from the channels' next-cycle rise so it lands with btn_press.
   always_ff @(posedge clk) begin
      if (rst) any_press <= 1'b0;
      else     any_press <= |rise_next;
   end

endmodule

// File: tb/tb_btn_event_handler.sv
// Scoreboard bench for btn_event_handler with short timing parameters.
module tb_btn_event_handler;

   localparam int NB  = 3;
   localparam int DEB = 8;
   localparam int LNG = 40;
   localparam int REP = 10;
   localparam int LAT = 2 + DEB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NB-1:0] btn = '0;
   logic [NB-1:0] btn_level, btn_press, btn_release, btn_long, btn_repeat;
   logic          any_press;

   int cyc    = 0;
   int n_cmp  = 0;
   int n_bad  = 0;

   typedef struct {
      int kind;
      int ch;
      int cyc;
   } ev_t;
   ev_t sb[$];

   btn_event_handler #(
      .NUM_BTN         (NB),
      .DEBOUNCE_CYCLES (DEB),
      .LONG_CYCLES     (LNG),
      .REPEAT_CYCLES   (REP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn         (btn),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_long    (btn_long),
      .btn_repeat  (btn_repeat),
      .any_press   (any_press)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic string kname(input int k);
      case (k)
         0:       return "press";
         1:       return "release";
         2:       return "long";
         3:       return "repeat";
         default: return "any_press";
      endcase
   endfunction

   function automatic logic pulse(input int k, input int ch);
      case (k)
         0:       return btn_press[ch];
         1:       return btn_release[ch];
         2:       return btn_long[ch];
         3:       return btn_repeat[ch];
         default: return any_press;
      endcase
   endfunction

   task automatic expect_ev(input int kind, input int ch, input int at);
      sb.push_back('{kind: kind, ch: ch, cyc: at});
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Every observed pulse must match the oldest queued expectation of its
   // kind/channel at the exact cycle; expectations left behind are misses.
   always @(negedge clk) begin
      int now;
      now = cyc;
      for (int k = 0; k < 5; k++) begin
         for (int ch = 0; ch < ((k == 4) ? 1 : NB); ch++) begin
            if (pulse(k, ch)) begin
               int idx;
               idx = -1;
               foreach (sb[i]) if (idx < 0 && sb[i].kind == k && sb[i].ch == ch) idx = i;
               if (idx >= 0) begin
                  chk($sformatf("%s[%0d]_cycle", kname(k), ch), now, sb[idx].cyc);
                  sb.delete(idx);
               end else begin
                  chk($sformatf("%s[%0d]_unexpected", kname(k), ch), now, -1);
               end
            end
         end
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc < now) begin
            chk($sformatf("%s[%0d]_missed", kname(sb[i].kind), sb[i].ch), now, sb[i].cyc);
            sb.delete(i);
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_level"},   int'(btn_level),   0);
      chk({tag, "_press"},   int'(btn_press),   0);
      chk({tag, "_release"}, int'(btn_release), 0);
      chk({tag, "_long"},    int'(btn_long),    0);
      chk({tag, "_repeat"},  int'(btn_repeat),  0);
      chk({tag, "_any"},     int'(any_press),   0);
   endtask

   initial begin
      int c;

      // reset state
      step(3);
      chk_all_zero("reset");
      rst = 1'b0;
      step(5);

      // clean press / release on channel 0
      c = cyc;
      btn[0] = 1'b1;
      expect_ev(0, 0, c + LAT);
      expect_ev(4, 0, c + LAT);
      step(20);
      chk("clean_level_hi", int'(btn_level[0]), 1);
      c = cyc;
      btn[0] = 1'b0;
      expect_ev(1, 0, c + LAT);
      step(15);
      chk("clean_level_lo", int'(btn_level[0]), 0);

      // bounce on channel 1: toggle every 3 cycles, then hold high
      for (int seg = 0; seg < 10; seg++) begin
         btn[1] = (seg % 2 == 0);
         step(3);
      end
      c = cyc;
      btn[1] = 1'b1;
      expect_ev(0, 1, c + LAT);
      expect_ev(4, 0, c + LAT);
      step(15);
      chk("bounce_level_hi", int'(btn_level[1]), 1);
      c = cyc;
      btn[1] = 1'b0;
      expect_ev(1, 1, c + LAT);
      step(15);

      // long press on channel 2, held 80 cycles; last repeat tick meets release
      c = cyc;
      btn[2] = 1'b1;
      expect_ev(0, 2, c + LAT);
      expect_ev(4, 0, c + LAT);
      expect_ev(2, 2, c + LAT + LNG);
`ifdef BTN_AUTOREPEAT_EN
      expect_ev(3, 2, c + LAT + LNG + REP);
      expect_ev(3, 2, c + LAT + LNG + 2 * REP);
      expect_ev(3, 2, c + LAT + LNG + 3 * REP);
`endif
      step(80);
      c = cyc;
      btn[2] = 1'b0;
      expect_ev(1, 2, c + LAT);
      step(15);

      // release accepted exactly when hold_cnt reaches LONG_CYCLES-1
      c = cyc;
      btn[2] = 1'b1;
      expect_ev(0, 2, c + LAT);
      expect_ev(4, 0, c + LAT);
      step(LNG);
      btn[2] = 1'b0;
      expect_ev(1, 2, c + LNG + LAT);
      step(15);

      // reset for 2 cycles while channel 0 is PRESSED
      c = cyc;
      btn[0] = 1'b1;
      expect_ev(0, 0, c + LAT);
      expect_ev(4, 0, c + LAT);
      step(20);
      rst = 1'b1;
      step(1);
      chk_all_zero("midreset");
      step(1);
      c = cyc;
      rst = 1'b0;
      expect_ev(0, 0, c + LAT);
      expect_ev(4, 0, c + LAT);
      step(20);
      chk("midreset_level_hi", int'(btn_level[0]), 1);
      c = cyc;
      btn[0] = 1'b0;
      expect_ev(1, 0, c + LAT);
      step(15);

      // all three channels together
      c = cyc;
      btn = '1;
      for (int ch = 0; ch < NB; ch++) expect_ev(0, ch, c + LAT);
      expect_ev(4, 0, c + LAT);
      step(15);
      chk("simul_level", int'(btn_level), 7);
      c = cyc;
      btn = '0;
      for (int ch = 0; ch < NB; ch++) expect_ev(1, ch, c + LAT);
      step(15);
      chk("simul_level_lo", int'(btn_level), 0);

      step(5);
      chk("sb_leftover", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
